// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types and constants for the byte serializer: the
//                transmitter state encoding and parameter limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // Transmitter states: waiting for a word, shifting bits out, forced idle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } ser_state_t;

    localparam int SER_WIDTH_DEFAULT = 8;
    localparam int SER_GAP_MAX       = 15;

    // Gap counter is sized for the largest supported gap
    localparam int SER_GAP_CNT_W     = 4;

    // Last value the gap counter reaches before returning to IDLE
    function automatic logic [SER_GAP_CNT_W-1:0] gap_last(input int gap);
        if (gap > 0) begin
            gap_last = SER_GAP_CNT_W'(gap - 1);
        end else begin
            gap_last = '0;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shreg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shreg
//  Description : Parallel-load, shift-left register. Exposes the MSB as the
//                serial bit; zeros enter at the LSB on every shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Next register value: a load takes priority over a shift
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = d;
        end else if (shift) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    // Register update with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb = shreg_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serializer
//  Description : Parallel-in, serial-out transmitter. Accepts one word per
//                load/ready handshake and shifts it out MSB-first on S with
//                enable high, then pulses done and optionally holds a number
//                of forced idle cycles before accepting the next word.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             S,
    output logic             enable,
    output logic             done
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [SER_GAP_CNT_W-1:0] GAP_LAST = gap_last(GAP);
    localparam logic [SER_GAP_CNT_W-1:0] GAP_ONE  = SER_GAP_CNT_W'(1);
    localparam logic               HAS_GAP  = (GAP > 0);

    ser_state_t                 state_q;
    ser_state_t                 state_d;
    logic [CNT_W-1:0]           bit_cnt_q;
    logic [CNT_W-1:0]           bit_cnt_d;
    logic [SER_GAP_CNT_W-1:0]   gap_cnt_q;
    logic [SER_GAP_CNT_W-1:0]   gap_cnt_d;
    logic                       done_q;
    logic                       done_d;

    logic                       w_accept;
    logic                       w_shift;
    logic                       w_msb;

    // Next-state, counter and done-pulse logic for the transmit sequence
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        w_accept  = 1'b0;
        w_shift   = 1'b0;
        case (state_q)
            serial_pkg::IDLE: begin
                if (load) begin
                    w_accept  = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = serial_pkg::SEND;
                end
            end
            serial_pkg::SEND: begin
                w_shift = 1'b1;
                if (bit_cnt_q == CNT_LAST) begin
                    // Last bit leaves S at this edge; counter is parked at 0
                    // instead of stepping past WIDTH-1.
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    if (HAS_GAP) begin
                        state_d = serial_pkg::GAP;
                    end else begin
                        state_d = serial_pkg::IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end
            serial_pkg::GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = serial_pkg::IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_ONE;
                end
            end
            default: begin
                state_d   = serial_pkg::IDLE;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end
        endcase
    end

    // State, counters and done register; reset overrides a same-cycle load
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= serial_pkg::IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            done_q    <= done_d;
        end
    end

    piso_shreg #(
        .WIDTH (WIDTH)
    ) u_piso_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (w_accept),
        .shift (w_shift),
        .d     (data_in),
        .msb   (w_msb)
    );

    // Outputs decode only registered state, never load or data_in
    assign ready  = (state_q == serial_pkg::IDLE);
    assign enable = (state_q == serial_pkg::SEND);
    assign S      = (state_q == serial_pkg::SEND) & w_msb;
    assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_serializer
//  Description : Directed self-checking bench for byte_serializer. Three
//                instances cover WIDTH=8/GAP=1, WIDTH=8/GAP=0 and
//                WIDTH=4/GAP=3. A model of the 8-bit serial receiver is
//                driven from the first instance for loopback checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_serializer;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] data_a;
    logic       load_a;
    logic       ready_a, s_a, en_a, done_a;

    logic [7:0] data_b;
    logic       load_b;
    logic       ready_b, s_b, en_b, done_b;

    logic [3:0] data_c;
    logic       load_c;
    logic       ready_c, s_c, en_c, done_c;

    logic [7:0] rx_q = 8'h00;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    byte_serializer #(.WIDTH(8), .GAP(1)) u_a (
        .clk(clk), .reset(rst), .data_in(data_a), .load(load_a),
        .ready(ready_a), .S(s_a), .enable(en_a), .done(done_a)
    );

    byte_serializer #(.WIDTH(8), .GAP(0)) u_b (
        .clk(clk), .reset(rst), .data_in(data_b), .load(load_b),
        .ready(ready_b), .S(s_b), .enable(en_b), .done(done_b)
    );

    byte_serializer #(.WIDTH(4), .GAP(3)) u_c (
        .clk(clk), .reset(rst), .data_in(data_c), .load(load_c),
        .ready(ready_c), .S(s_c), .enable(en_c), .done(done_c)
    );

    // Receiver model: shifts S in at the LSB while enable is high
    always @(posedge clk) begin
        if (en_a) rx_q <= {rx_q[6:0], s_a};
    end

    function automatic logic rx_sel(input logic [7:0] q, input int idx);
        return q[idx];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame on instance A; optionally pokes load with another word
    // during SEND cycle poke_at (ignored because the block is busy).
    task automatic frame_a(input logic [7:0] w, input int poke_at, input logic [7:0] poke_w);
        data_a = w;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        data_a = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == poke_at) begin
                load_a = 1'b1;
                data_a = poke_w;
            end else begin
                load_a = 1'b0;
            end
            chk($sformatf("a_s_%02h_b%0d", w, 7 - i), {31'd0, s_a}, {31'd0, w[7-i]});
            chk($sformatf("a_en_%02h_b%0d", w, 7 - i), {31'd0, en_a}, 32'd1);
            chk($sformatf("a_rdy_%02h_b%0d", w, 7 - i), {31'd0, ready_a}, 32'd0);
            tick();
        end
        load_a = 1'b0;
        chk("a_done_hi", {31'd0, done_a}, 32'd1);
        chk("a_en_lo_gap", {31'd0, en_a}, 32'd0);
        chk("a_rdy_lo_gap", {31'd0, ready_a}, 32'd0);
        chk("a_rx_word", {24'd0, rx_q}, {24'd0, w});
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a_rx_sel%0d_%02h", i, w), {31'd0, rx_sel(rx_q, i)}, {31'd0, w[i]});
        end
        tick();
        chk("a_done_lo", {31'd0, done_a}, 32'd0);
        chk("a_rdy_back", {31'd0, ready_a}, 32'd1);
        chk("a_en_idle", {31'd0, en_a}, 32'd0);
    endtask

    initial begin
        logic [7:0] w12;
        logic [7:0] w34;
        logic [3:0] w9;
        w12 = 8'h12;
        w34 = 8'h34;
        w9  = 4'h9;

        rst = 1'b1;
        load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
        data_a = 8'h00; data_b = 8'h00; data_c = 4'h0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", {31'd0, ready_a}, 32'd1);
        chk("rst_s", {31'd0, s_a}, 32'd0);
        chk("rst_en", {31'd0, en_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);

        // Basic frame and loopback words
        frame_a(8'hA5, -1, 8'h00);
        frame_a(8'h3C, -1, 8'h00);
        frame_a(8'hFF, -1, 8'h00);
        frame_a(8'h00, -1, 8'h00);

        // Load while busy is dropped; no second frame follows
        frame_a(8'hF0, 3, 8'h0F);
        for (int i = 0; i < 3; i++) begin
            chk("a_no_second_frame", {31'd0, en_a}, 32'd0);
            chk("a_no_second_done", {31'd0, done_a}, 32'd0);
            tick();
        end

        // Reset in the 4th SEND cycle aborts the frame
        data_a = 8'h81;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("a_abort_pre_en", {31'd0, en_a}, 32'd1);
            tick();
        end
        rst = 1'b1;
        load_a = 1'b1;
        tick();
        rst = 1'b0;
        load_a = 1'b0;
        chk("a_abort_en", {31'd0, en_a}, 32'd0);
        chk("a_abort_done", {31'd0, done_a}, 32'd0);
        chk("a_abort_ready", {31'd0, ready_a}, 32'd1);
        tick();
        chk("a_abort_done2", {31'd0, done_a}, 32'd0);
        chk("a_abort_en2", {31'd0, en_a}, 32'd0);
        frame_a(8'h81, -1, 8'h00);

        // GAP=0, load held high: two frames with one enable-low cycle
        data_b = w12;
        load_b = 1'b1;
        tick();
        data_b = w34;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b_s12_b%0d", 7 - i), {31'd0, s_b}, {31'd0, w12[7-i]});
            chk("b_en12", {31'd0, en_b}, 32'd1);
            tick();
        end
        chk("b_done1", {31'd0, done_b}, 32'd1);
        chk("b_ready1", {31'd0, ready_b}, 32'd1);
        chk("b_en_gap", {31'd0, en_b}, 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) load_b = 1'b0;
            chk($sformatf("b_s34_b%0d", 7 - i), {31'd0, s_b}, {31'd0, w34[7-i]});
            chk("b_en34", {31'd0, en_b}, 32'd1);
            chk("b_done_mid", {31'd0, done_b}, 32'd0);
            tick();
        end
        chk("b_done2", {31'd0, done_b}, 32'd1);
        chk("b_en_end", {31'd0, en_b}, 32'd0);
        tick();
        chk("b_done_lo", {31'd0, done_b}, 32'd0);
        chk("b_no_third", {31'd0, en_b}, 32'd0);

        // WIDTH=4, GAP=3
        data_c = w9;
        load_c = 1'b1;
        tick();
        load_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("c_s_b%0d", 3 - i), {31'd0, s_c}, {31'd0, w9[3-i]});
            chk("c_en", {31'd0, en_c}, 32'd1);
            tick();
        end
        chk("c_done", {31'd0, done_c}, 32'd1);
        chk("c_en_off", {31'd0, en_c}, 32'd0);
        chk("c_rdy_gap0", {31'd0, ready_c}, 32'd0);
        for (int i = 1; i < 3; i++) begin
            tick();
            chk($sformatf("c_rdy_gap%0d", i), {31'd0, ready_c}, 32'd0);
            chk("c_done_gap", {31'd0, done_c}, 32'd0);
        end
        tick();
        chk("c_rdy_back", {31'd0, ready_c}, 32'd1);
        chk("c_en_idle", {31'd0, en_c}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
